// File: rtl/intf_data_checker.sv
`default_nettype none
// ============================================================================
// intf_data_checker : compares WINDOW accepted beats against EXP_DATA and
// reports match/mismatch counts. Optional macro INTF_DATA_CHECKER_FIRST_ERR_EN
// adds capture of the first mismatching beat (data and index).
// Rev 1.0
// ============================================================================
module intf_data_checker #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] EXP_DATA = 8'hFF,
  parameter int                WINDOW   = 256,
  parameter int                CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_a,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [CNT_W-1:0]  o_match_cnt,
  output logic [CNT_W-1:0]  o_mism_cnt,
  output logic              o_err
`ifdef INTF_DATA_CHECKER_FIRST_ERR_EN
  ,
  output logic [DATA_W-1:0] o_first_err_data,
  output logic [CNT_W-1:0]  o_first_err_idx
`endif
);

  localparam int               IDX_W    = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic w_accept;
  logic w_hit;
  logic w_start_run;

  assign w_accept    = i_a_valid && ready_q;
  assign w_hit       = (i_a == EXP_DATA);
  // A start pulse is only honoured outside of an active run.
  assign w_start_run = i_start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    mism_d  = mism_q;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (w_start_run) begin
          state_d = RUN;
          match_d = '0;
          mism_d  = '0;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (w_accept) begin
          if (w_hit) begin
            if (match_q != CNT_MAX) match_d = match_q + CNT_W'(1);
          end else begin
            if (mism_q != CNT_MAX) mism_d = mism_q + CNT_W'(1);
            err_d = 1'b1;
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready is registered from the next state so it never depends on i_a_valid.
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      match_q <= '0;
      mism_q  <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      match_q <= match_d;
      mism_q  <= mism_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign o_a_ready   = ready_q;
  assign o_busy      = (state_q == RUN);
  assign o_done      = (state_q == DONE);
  assign o_pass      = (state_q == DONE) && (mism_q == '0);
  assign o_match_cnt = match_q;
  assign o_mism_cnt  = mism_q;
  assign o_err       = err_q;

`ifdef INTF_DATA_CHECKER_FIRST_ERR_EN
  logic [DATA_W-1:0] fe_data_q, fe_data_d;
  logic [CNT_W-1:0]  fe_idx_q, fe_idx_d;

  // err_q still low means this mismatch is the first one of the run.
  always_comb begin
    fe_data_d = fe_data_q;
    fe_idx_d  = fe_idx_q;
    if (w_start_run) begin
      fe_data_d = '0;
      fe_idx_d  = '0;
    end else if ((state_q == RUN) && w_accept && !w_hit && !err_q) begin
      fe_data_d = i_a;
      fe_idx_d  = CNT_W'(idx_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fe_data_q <= '0;
      fe_idx_q  <= '0;
    end else begin
      fe_data_q <= fe_data_d;
      fe_idx_q  <= fe_idx_d;
    end
  end

  assign o_first_err_data = fe_data_q;
  assign o_first_err_idx  = fe_idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_intf_data_checker.sv
`default_nettype none
`timescale 1ns/1ps
// tb_intf_data_checker : table of check runs with a per-beat scoreboard, plus
// hand sequences for reset abort, counter saturation and a one-beat window.
module tb_intf_data_checker;

  localparam int WINDOW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (default parameters)
  logic [7:0]  a = 8'h00;
  logic        valid = 1'b0, start = 1'b0;
  logic        ready, busy, done, pass, err;
  logic [15:0] mcnt, xcnt;
  // saturation DUT
  logic [7:0]  b_a = 8'h00;
  logic        b_valid = 1'b0, b_start = 1'b0;
  logic        b_ready, b_busy, b_done, b_pass, b_err;
  logic [3:0]  b_mcnt, b_xcnt;
  // single-beat-window DUT
  logic [7:0]  c_a = 8'h00;
  logic        c_valid = 1'b0, c_start = 1'b0;
  logic        c_ready, c_busy, c_done, c_pass, c_err;
  logic [15:0] c_mcnt, c_xcnt;
`ifdef INTF_DATA_CHECKER_FIRST_ERR_EN
  logic [7:0]  fe_data, b_fe_data, c_fe_data;
  logic [15:0] fe_idx, c_fe_idx;
  logic [3:0]  b_fe_idx;
`endif

  intf_data_checker u_dut (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_a_valid(valid), .o_a_ready(ready),
    .i_start(start), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_match_cnt(mcnt), .o_mism_cnt(xcnt), .o_err(err)
`ifdef INTF_DATA_CHECKER_FIRST_ERR_EN
    , .o_first_err_data(fe_data), .o_first_err_idx(fe_idx)
`endif
  );

  intf_data_checker #(.CNT_W(4), .WINDOW(20)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_a(b_a), .i_a_valid(b_valid), .o_a_ready(b_ready),
    .i_start(b_start), .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_match_cnt(b_mcnt), .o_mism_cnt(b_xcnt), .o_err(b_err)
`ifdef INTF_DATA_CHECKER_FIRST_ERR_EN
    , .o_first_err_data(b_fe_data), .o_first_err_idx(b_fe_idx)
`endif
  );

  intf_data_checker #(.WINDOW(1)) u_one (
    .i_clk(clk), .i_rst(rst), .i_a(c_a), .i_a_valid(c_valid), .o_a_ready(c_ready),
    .i_start(c_start), .o_busy(c_busy), .o_done(c_done), .o_pass(c_pass),
    .o_match_cnt(c_mcnt), .o_mism_cnt(c_xcnt), .o_err(c_err)
`ifdef INTF_DATA_CHECKER_FIRST_ERR_EN
    , .o_first_err_data(c_fe_data), .o_first_err_idx(c_fe_idx)
`endif
  );

  typedef struct {
    logic [7:0] base;
    logic [7:0] bad_val;
    int         bad_pos;
    int         start_at;
    int         abort_at;
    bit         toggle;
    int         exp_match;
    int         exp_mism;
    int         exp_run_cyc;
    bit         exp_pass;
    logic [7:0] exp_fe_data;
    int         exp_fe_idx;
  } vec_t;

  typedef struct {
    int m;
    int x;
    bit e;
  } sb_t;

  vec_t tbl[5];
  sb_t  sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_pass"},  pass, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_match"}, mcnt, 0);
    chk({tag, "_mism"},  xcnt, 0);
`ifdef INTF_DATA_CHECKER_FIRST_ERR_EN
    chk({tag, "_fe_data"}, fe_data, 0);
    chk({tag, "_fe_idx"},  fe_idx, 0);
`endif
  endtask

  // One check run on the main DUT; the model pushes the expected counters for
  // each accepted beat and they are popped once the DUT has registered it.
  task automatic run_vec(input int v);
    vec_t t = tbl[v];
    int   beat = 0, cyc = 0, busy_cyc = 0;
    int   m = 0, x = 0;
    bit   e = 1'b0, acc;
    sb_t  cur, nx;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_match0", mcnt, 0);
    chk("start_mism0", xcnt, 0);
    chk("start_err0", err, 0);
    chk("start_done0", done, 0);
    cur = '{0, 0, 1'b0};
    while (beat < WINDOW && cyc < 4 * WINDOW && beat != t.abort_at) begin
      valid = t.toggle ? (cyc % 2 == 1) : 1'b1;
      a     = (beat == t.bad_pos) ? t.bad_val : t.base;
      start = (beat == t.start_at) && valid;
      if (busy) busy_cyc++;
      chk("run_ready", ready, 1);
      acc = valid;
      if (acc) begin
        if (a == 8'hFF) begin
          if (m < 65535) m++;
        end else begin
          if (x < 65535) x++;
          e = 1'b1;
        end
        nx = '{m, x, e};
        sbq.push_back(nx);
      end
      step();
      start = 1'b0;
      if (acc) begin
        cur = sbq.pop_front();
        beat++;
      end
      chk("sb_match", mcnt, cur.m);
      chk("sb_mism", xcnt, cur.x);
      chk("sb_err", err, cur.e);
      cyc++;
    end
    valid = 1'b0;
    start = 1'b0;
    if (beat != t.abort_at) begin
      chk("beats_accepted", beat, WINDOW);
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_ready", ready, 0);
      chk("end_match", mcnt, t.exp_match);
      chk("end_mism", xcnt, t.exp_mism);
      chk("end_pass", pass, t.exp_pass);
      chk("end_err", err, (t.exp_mism > 0));
      chk("run_cycles", busy_cyc, t.exp_run_cyc);
`ifdef INTF_DATA_CHECKER_FIRST_ERR_EN
      chk("end_fe_data", fe_data, t.exp_fe_data);
      chk("end_fe_idx", fe_idx, t.exp_fe_idx);
`endif
      step();
      chk("hold_done", done, 1);
      chk("hold_match", mcnt, t.exp_match);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //         base   bad_val bad  start abort tog  match mism cyc  pass fe_d   fe_i
    tbl[0] = '{8'hFF, 8'h00,  -1,  -1,   -1,   1'b0, 256, 0,   256, 1'b1, 8'h00, 0};
    tbl[1] = '{8'hFF, 8'h7F,  10,  100,  -1,   1'b0, 255, 1,   256, 1'b0, 8'h7F, 10};
    tbl[2] = '{8'hFF, 8'h00,  -1,  -1,   -1,   1'b1, 256, 0,   512, 1'b1, 8'h00, 0};
    tbl[3] = '{8'hFF, 8'hFE,  255, -1,   -1,   1'b0, 255, 1,   256, 1'b0, 8'hFE, 255};
    tbl[4] = '{8'hFF, 8'h00,  5,   -1,   100,  1'b0, 0,   0,   0,   1'b0, 8'h00, 0};

    // reset with a coincident start: start must be ignored
    rst   = 1'b1;
    start = 1'b1;
    step();
    step();
    chk_idle("rst");
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk_idle("post_rst");

    for (int i = 0; i < 4; i++) run_vec(i);

    // abort after 100 beats, reset with start in the same cycle
    run_vec(4);
    chk("abort_err", err, 1);
    chk("abort_match", mcnt, 99);
    rst   = 1'b1;
    start = 1'b1;
    step();
    chk_idle("abort");
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk_idle("abort_idle");
    run_vec(0);

    // CNT_W=4, WINDOW=20, all-zero beats: mismatch counter saturates
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("sat_busy", b_busy, 1);
    for (int i = 0; i < 20; i++) begin
      b_valid = 1'b1;
      b_a     = 8'h00;
      chk("sat_ready", b_ready, 1);
      step();
      chk("sat_mism", b_xcnt, (i + 1 > 15) ? 15 : i + 1);
      chk("sat_match", b_mcnt, 0);
      chk("sat_err", b_err, 1);
      chk("sat_done", b_done, (i == 19));
    end
    b_valid = 1'b0;
    chk("sat_pass", b_pass, 0);
    chk("sat_ready_end", b_ready, 0);
`ifdef INTF_DATA_CHECKER_FIRST_ERR_EN
    chk("sat_fe_data", b_fe_data, 8'h00);
    chk("sat_fe_idx", b_fe_idx, 0);
`endif

    // WINDOW=1: one accepted beat finishes the run
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    chk("one_ready", c_ready, 1);
    c_valid = 1'b1;
    c_a     = 8'hFF;
    step();
    c_valid = 1'b0;
    chk("one_done", c_done, 1);
    chk("one_match", c_mcnt, 1);
    chk("one_pass", c_pass, 1);
    chk("one_ready_end", c_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
